lightgun_hvlatch: RTL and testbench

LIGHTGUN_HVLATCH -- requirements
Module: lightgun_hvlatch

---
 rtl/lightgun_hvlatch.sv | 93 +++++++++
 tb/tb_lightgun_hvlatch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lightgun_hvlatch.sv
// lightgun_hvlatch: latches beam position on a light-gun sensor hit, one capture per frame.
// Optional LG_HVLATCH_DEBOUNCE_EN requires DEB_LEN consecutive high sensor samples per hit.
module lightgun_hvlatch #(
    parameter int DEB_LEN = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE_PIX,
    input  logic       HDE,
    input  logic       VDE,
    input  logic       SENSOR,
    input  logic       LATCH_EN,
    input  logic       RD_STAT,
    output logic [9:0] HCT,
    output logic [8:0] VCT,
    output logic       EXLTFG
);
    logic [9:0] hcnt;
    logic [8:0] vcnt;
    logic       hde_q, vde_q, lock;
    logic       hit, cap;
    logic [9:0] hit_h;
    logic [8:0] hit_v;

    if (DEB_LEN < 1) begin : g_bad_len
        $error("DEB_LEN must be at least 1");
    end

`ifdef LG_HVLATCH_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_LEN + 1);
    logic [CW-1:0] run;
    logic [9:0]    snap_h;
    logic [8:0]    snap_v;
    // The hit reports where the run started, not where it was confirmed.
    assign hit   = SENSOR && LATCH_EN && run == CW'(DEB_LEN - 1);
    assign hit_h = run == '0 ? hcnt : snap_h;
    assign hit_v = run == '0 ? vcnt : snap_v;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            run    <= '0;
            snap_h <= '0;
            snap_v <= '0;
        end else if (CE_PIX) begin
            if (!LATCH_EN || !SENSOR) begin
                run <= '0;
            end else begin
                if (run == '0) begin
                    snap_h <= hcnt;
                    snap_v <= vcnt;
                end
                if (run != CW'(DEB_LEN)) run <= run + 1'b1;
            end
        end
    end
`else
    logic sens_q;
    assign hit   = SENSOR && !sens_q;
    assign hit_h = hcnt;
    assign hit_v = vcnt;
    always_ff @(posedge CLK) begin
        if (RESET) sens_q <= 1'b0;
        else if (CE_PIX) sens_q <= SENSOR;
    end
`endif

    assign cap = CE_PIX && hit && LATCH_EN && VDE && !lock;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hcnt   <= '0;
            vcnt   <= '0;
            hde_q  <= 1'b0;
            vde_q  <= 1'b0;
            lock   <= 1'b0;
            HCT    <= '0;
            VCT    <= '0;
            EXLTFG <= 1'b0;
        end else begin
            if (CE_PIX) begin
                hcnt  <= !HDE ? '0 : (&hcnt ? hcnt : hcnt + 10'd1);
                vcnt  <= !VDE ? '0 : ((hde_q && !HDE && !(&vcnt)) ? vcnt + 9'd1 : vcnt);
                hde_q <= HDE;
                vde_q <= VDE;
                lock  <= cap || (lock && !(VDE && !vde_q));
            end
            if (cap) begin
                HCT <= hit_h;
                VCT <= hit_v;
            end
            EXLTFG <= cap || (EXLTFG && !RD_STAT);
        end
    end
endmodule

// File: tb/tb_lightgun_hvlatch.sv
// tb_lightgun_hvlatch: directed scoreboard bench for lightgun_hvlatch (both debounce builds).
module tb_lightgun_hvlatch;
    logic       clk = 1'b0;
    logic       rst, ce_pix, hde, vde, sensor, latch_en, rd_stat;
    logic [9:0] hct;
    logic [8:0] vct;
    logic       exltfg;
    int         total = 0;
    int         bad = 0;

`ifdef LG_HVLATCH_DEBOUNCE_EN
    localparam int PL = 4;
`else
    localparam int PL = 1;
`endif

    typedef struct {
        string      tag;
        logic [9:0] h;
        logic [8:0] v;
        logic       f;
    } exp_t;
    exp_t sb[$];

    lightgun_hvlatch #(.DEB_LEN(4)) dut (
        .CLK(clk), .RESET(rst), .CE_PIX(ce_pix), .HDE(hde), .VDE(vde),
        .SENSOR(sensor), .LATCH_EN(latch_en), .RD_STAT(rd_stat),
        .HCT(hct), .VCT(vct), .EXLTFG(exltfg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [9:0] h, input logic [8:0] v, input logic f);
        exp_t e;
        e.tag = tag; e.h = h; e.v = v; e.f = f;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard: empty queue, observed hct=%0d vct=%0d flag=%0b", hct, vct, exltfg);
        end else begin
            e = sb.pop_front();
            assert ({hct, vct, exltfg} === {e.h, e.v, e.f}) else begin
                bad++;
                $error("FAIL %s: observed hct=%0d vct=%0d flag=%0b expected hct=%0d vct=%0d flag=%0b",
                       e.tag, hct, vct, exltfg, e.h, e.v, e.f);
            end
        end
    endtask

    // One active line of len pixels, optional sensor pulse, then two blanking pixels.
    task automatic run_line(input int len, input int pat, input int plen, input bit rd,
                            input string tag, input logic [9:0] h, input logic [8:0] v, input logic f);
        bit last;
        for (int i = 0; i < len; i++) begin
            last    = pat >= 0 && i == pat + plen - 1;
            hde     = 1'b1;
            sensor  = pat >= 0 && i >= pat && i < pat + plen;
            rd_stat = rd && last;
            if (last) push(tag, h, v, f);
            step();
            if (last) check();
        end
        hde = 1'b0; sensor = 1'b0; rd_stat = 1'b0;
        step();
        step();
    endtask

    task automatic frame(input int n);
        hde = 1'b0; sensor = 1'b0; rd_stat = 1'b0; vde = 1'b0;
        repeat (3) step();
        vde = 1'b1;
        step();
        for (int l = 0; l < n; l++) run_line(4, -1, 0, 1'b0, "", '0, '0, 1'b0);
    endtask

    task automatic rd_pulse(input string tag, input logic [9:0] h, input logic [8:0] v, input logic f);
        rd_stat = 1'b1;
        push(tag, h, v, f);
        step();
        check();
        rd_stat = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce_pix = 1'b1; hde = 1'b0; vde = 1'b0; sensor = 1'b1;
        latch_en = 1'b1; rd_stat = 1'b1;
        push("reset", 10'd0, 9'd0, 1'b0);
        step(); step();
        check();
        rst = 1'b0; rd_stat = 1'b0;
        push("first_after_reset", 10'd0, 9'd0, 1'b0);
        step();
        check();
        sensor = 1'b0;
        step();

        latch_en = 1'b0;
        frame(5);
        run_line(20, 10, PL, 1'b0, "latch_en_low", 10'd0, 9'd0, 1'b0);
        latch_en = 1'b1; vde = 1'b0; hde = 1'b1;
        for (int i = 0; i < PL; i++) begin
            sensor = 1'b1;
            if (i == PL - 1) push("vde_low", 10'd0, 9'd0, 1'b0);
            step();
            if (i == PL - 1) check();
        end
        sensor = 1'b0; hde = 1'b0;
        step();

        frame(50);
        run_line(110, 100, PL, 1'b0, "capture_100_50", 10'd100, 9'd50, 1'b1);
        run_line(210, 200, PL, 1'b0, "frame_lock", 10'd100, 9'd50, 1'b1);
        rd_pulse("rd_alone", 10'd100, 9'd50, 1'b0);

        frame(60);
        run_line(210, 200, PL, 1'b1, "capture_rd_coincide", 10'd200, 9'd60, 1'b1);

        frame(2);
        ce_pix = 1'b0; hde = 1'b1; sensor = 1'b1;
        repeat (4) step();
        push("ce_pix_low", 10'd200, 9'd60, 1'b1);
        step();
        check();
        sensor = 1'b0;
        step();
        ce_pix = 1'b1;
        run_line(20, 3, PL, 1'b0, "ce_resume", 10'd3, 9'd2, 1'b1);

        frame(1);
        run_line(1032, 1026, PL, 1'b0, "hcnt_sat", 10'd1023, 9'd1, 1'b1);

        frame(515);
        run_line(10, 4, PL, 1'b0, "vcnt_sat", 10'd4, 9'd511, 1'b1);

        hde = 1'b1; vde = 1'b1; rst = 1'b1;
        push("reset_mid_frame", 10'd0, 9'd0, 1'b0);
        step();
        check();
        rst = 1'b0;
        run_line(20, 5, PL, 1'b0, "restart_counts", 10'd5, 9'd0, 1'b1);

`ifdef LG_HVLATCH_DEBOUNCE_EN
        frame(3);
        rd_pulse("deb_clear", 10'd5, 9'd0, 1'b0);
        run_line(30, 5, 3, 1'b0, "deb_short", 10'd5, 9'd0, 1'b0);
        run_line(160, 120, 4, 1'b0, "deb_full", 10'd120, 9'd4, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
